// File: rtl/pfi_sched.sv
// pfi_sched: feeds a symbol packer from two requesters and drains it in frames.
// The join side is a combinational two-way round-robin arbiter. The pop side is
// a small IDLE/RUN/DONE machine that asks for chunks of at most 16 symbols
// until the requested frame length has been popped.
module pfi_sched #(
    parameter int FRAME_W = 10
) (
    input  logic               i_core_clk,
    input  logic               i_rx_rst,
    // requester 0
    input  logic               rq0_valid,
    input  logic [3:0]         rq0_amount,
    input  logic [95:0]        rq0_data,
    output logic               rq0_ready,
    // requester 1
    input  logic               rq1_valid,
    input  logic [3:0]         rq1_amount,
    input  logic [95:0]        rq1_data,
    output logic               rq1_ready,
    // packer join side
    output logic               join_enable,
    output logic [3:0]         join_amount,
    output logic [95:0]        join_data,
    input  logic               join_permit,
    // packer pop side
    output logic               pop_permit,
    output logic [3:0]         pop_amount,
    input  logic               pop_enable,
    // frame control
    input  logic               cfg_start,
    input  logic [FRAME_W-1:0] cfg_frame_len,
    output logic               busy,
    output logic               frame_done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] remaining_q, remaining_d;
    logic               ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               pop_permit_q, pop_permit_d;
    logic [3:0]         pop_amount_q, pop_amount_d;

    // ---------------------------------------------------------------------
    // Join arbitration
    // ---------------------------------------------------------------------
    logic [1:0] rq_valid;
    logic [1:0] grant;
    logic       handshake;

    assign rq_valid = {rq1_valid, rq0_valid};

    // A requester wins if it is valid and either preferred or uncontested.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = rq_valid[gi] & ((ptr_q == 1'(gi)) | ~rq_valid[1-gi]);
        end
    endgenerate

    assign join_enable = |grant;
    assign rq0_ready   = grant[0] & join_permit;
    assign rq1_ready   = grant[1] & join_permit;
    assign handshake   = join_enable & join_permit;

    // Route the granted requester's payload; kept free of join_permit so the
    // packer's permit logic never closes a combinational loop through here.
    always_comb begin
        join_amount = '0;
        join_data   = '0;
        if (grant[0]) begin
            join_amount = rq0_amount;
            join_data   = rq0_data;
        end else if (grant[1]) begin
            join_amount = rq1_amount;
            join_data   = rq1_data;
        end
    end

    // After a handshake the other requester becomes preferred; stalls hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = grant[0];
        end
    end

    // ---------------------------------------------------------------------
    // Pop frame machine
    // ---------------------------------------------------------------------
    logic [4:0] chunk;
    logic [4:0] chunk_next;
    logic [4:0] chunk_next_m1;

    // Symbols popped this cycle: never more than what is left of the frame.
    assign chunk = (remaining_q >= FRAME_W'(16)) ? 5'd16 : remaining_q[4:0];

    // Next-state and next-output computation for the frame machine.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_frame_len != '0) begin
                        remaining_d = cfg_frame_len;
                        state_d     = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pop_enable) begin
                    remaining_d = remaining_q - FRAME_W'(chunk);
                    if (remaining_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up exactly
        // with the state they describe.
        chunk_next    = (remaining_d >= FRAME_W'(16)) ? 5'd16 : remaining_d[4:0];
        chunk_next_m1 = chunk_next - 5'd1;
        busy_d        = (state_d != ST_IDLE);
        frame_done_d  = (state_d == ST_DONE);
        pop_permit_d  = (state_d == ST_RUN);
        pop_amount_d  = (state_d == ST_RUN) ? chunk_next_m1[3:0] : 4'd0;
    end

    // All state and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            ptr_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            pop_permit_q <= 1'b0;
            pop_amount_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
            pop_permit_q <= pop_permit_d;
            pop_amount_q <= pop_amount_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign pop_permit = pop_permit_q;
    assign pop_amount = pop_amount_q;

endmodule
